serial_deserializer: RTL
========================

# serial_deserializer

Serial-in, parallel-out word assembler: the receive-side counterpart of the 8-bit load/shift register, which turns a bit stream back into words. It accepts one bit per qualified cycle, counts bits, and hands each completed word to a downstream consumer over a valid/ready handshake. It sits between a serial link front end and the byte-wide datapath. A sticky flag reports words lost to back-pressure.

## Interface
- WIDTH, 8, word width in bits (≥ 2)
- MSB_FIRST, 1, 1: first received bit lands in out_data[WIDTH-1]; 0: first bit lands in out_data[0]
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- sin_valid  input  1  sin_data carries a bit this cycle
- sin_data  input  1  serial data bit
- sin_sync  input  1  word boundary; discards any partial word
- out_data  output  WIDTH  completed word; stable while out_valid=1
- out_valid  output  1  out_data holds an unconsumed word
- out_ready  input  1  consumer accepts the word this cycle
- overrun  output  1  sticky; a completed word was dropped
- ovr_clr  input  1  clears overrun
- bit_cnt  output  $clog2(WIDTH+1)  bits of the current partial word

## Operation
- Reset values: shift register 0, bit_cnt 0, out_data 0, out_valid 0, overrun 0, state IDLE.
- States:
  - IDLE: bit_cnt=0.
  - SHIFT: 1 ≤ bit_cnt ≤ WIDTH-1.
- Accepted bit (sin_valid=1):
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], sin_data}.
  - MSB_FIRST=0: sr <= {sin_data, sr[WIDTH-1:1]}.
  - bit_cnt increments. IDLE→SHIFT on the first bit.
- Completion: the bit that makes the count reach WIDTH completes the word.
  - Assembled word goes to the output holding register.
  - bit_cnt returns to 0 and state returns to IDLE in the same edge. bit_cnt never reads WIDTH.
- sin_valid=0: sr and bit_cnt hold.
- sin_sync=1, sin_valid=0: bit_cnt←0, state IDLE, partial bits discarded. out_data and out_valid are unaffected.
- sin_sync=1, sin_valid=1: partial word discarded. The current bit becomes bit 1 of a new word (bit_cnt←1, state SHIFT).
- Output handshake:
  - out_valid rises on completion.
  - It holds with out_data frozen until a cycle with out_valid=1 and out_ready=1; out_valid then drops next edge.
- Completion while holding register is free, or freed this cycle (out_valid & out_ready): new word loaded, out_valid=1, no overrun. This gives back-to-back words with no bubble.
- Completion while holding register is full and out_ready=0: new word dropped, old word kept, overrun←1.
- overrun stays set until rst or ovr_clr. ovr_clr coinciding with a new overrun event leaves overrun=1 (set wins).
- out_ready while out_valid=0 is ignored.

## Timing
- Latency: the last bit sampled at edge N gives out_valid=1 with the correct out_data after edge N. Readable in cycle N+1.
- Sustained throughput: one word per WIDTH valid bits, with no dead cycles between words.
- rst mid-word or with a word pending:
  - All state cleared at the next edge; the partial word and pending word are lost.
  - overrun clears.
  - rst has priority over every other input.
- sin_sync, sin_valid and out_ready are all sampled at the same edge, with no ordering between them beyond the rules above.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package:
  - state typedef (IDLE, SHIFT)
  - default WIDTH constant
  - bit-count width function $clog2(WIDTH+1)
- Sub-module `deser_shift`:
  - WIDTH-bit shift register plus bit counter, with sync/clear and the MSB_FIRST direction select.
  - Emits `word_done` and the assembled word.
- Top level owns:
  - holding register
  - handshake and out_valid
  - overrun logic

## Test plan
- MSB_FIRST=1:
  - Bits 1,0,1,0,0,1,0,1 on consecutive cycles, out_ready=1 → out_valid for one cycle after the 8th edge, out_data=0xA5.
  - MSB_FIRST=0 with the same bits → out_data=0xA5 bit-reversed = 0xA5? No: expect 0xA5 reversed = 0xA5; use bits 1,1,0,0,0,0,0,0 → 0x03.
- Gapped input: 8 bits with sin_valid toggling every other cycle → bit_cnt steps 0..7 then 0; word correct; out_valid only after the 8th valid bit.
- sin_sync after 3 bits, then 8 bits of 0x3C → out_data=0x3C. No spurious word from the 3 discarded bits.
- Back-pressure:
  - out_ready=0; send 0x11 then 0x22 → out_data stays 0x11 and overrun=1.
  - ovr_clr → overrun=0.
  - out_ready=1 → out_valid drops.
- Back-to-back handshake:
  - out_ready asserted on the exact cycle the second word completes → out_data=0x22, out_valid stays 1, overrun=0.
- rst after 5 bits with a word pending → next cycle all outputs 0. A fresh 8 bits of 0xFF yields 0xFF.

Source files
------------

// File: rtl/serial_deserializer_pkg.sv
// Shared types and sizing helpers for the serial-in, parallel-out word assembler.
package serial_deserializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } deser_state_e;

  localparam int unsigned DEFAULT_WIDTH = 8;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_deserializer_shift.sv
// Shift register and bit counter: assembles WIDTH serial bits and flags the completing bit.
module deser_shift
  import serial_deserializer_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sin_valid,
  input  logic                          sin_data,
  input  logic                          sin_sync,
  output logic                          word_done,
  output logic [WIDTH-1:0]              word,
  output logic [cnt_width(WIDTH)-1:0]   bit_cnt
);

  localparam int unsigned   CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  deser_state_e     state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d, sr_base, sr_shift;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_base;

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    word_done = 1'b0;
    // A sync restarts the word, so the incoming bit (if any) builds on an empty register.
    sr_base   = sin_sync ? '0 : sr_q;
    cnt_base  = sin_sync ? '0 : cnt_q;
    if (MSB_FIRST) begin
      sr_shift = {sr_base[WIDTH-2:0], sin_data};
    end else begin
      sr_shift = {sin_data, sr_base[WIDTH-1:1]};
    end
    word = sr_shift;
    if (sin_valid) begin
      sr_d = sr_shift;
      if (cnt_base == LAST) begin
        word_done = 1'b1;
        cnt_d     = '0;
        state_d   = IDLE;
      end else begin
        cnt_d   = cnt_base + CW'(1);
        state_d = SHIFT;
      end
    end else if (sin_sync) begin
      sr_d    = '0;
      cnt_d   = '0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bit_cnt = cnt_q;

endmodule

// File: rtl/serial_deserializer.sv
// Serial-to-word assembler with a one-word holding register, valid/ready output and sticky overrun.
module serial_deserializer
  import serial_deserializer_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sin_valid,
  input  logic                          sin_data,
  input  logic                          sin_sync,
  output logic [WIDTH-1:0]              out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          overrun,
  input  logic                          ovr_clr,
  output logic [cnt_width(WIDTH)-1:0]   bit_cnt
);

  logic             word_done;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             hold_free;

  deser_shift #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk       (clk),
    .rst       (rst),
    .sin_valid (sin_valid),
    .sin_data  (sin_data),
    .sin_sync  (sin_sync),
    .word_done (word_done),
    .word      (word),
    .bit_cnt   (bit_cnt)
  );

  always_comb begin
    hold_d    = hold_q;
    valid_d   = valid_q;
    ovr_d     = ovr_q;
    // Register counts as free if it is empty or being consumed this cycle.
    hold_free = !valid_q || out_ready;
    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
    if (ovr_clr) begin
      ovr_d = 1'b0;
    end
    if (word_done) begin
      if (hold_free) begin
        hold_d  = word;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out_data  = hold_q;
  assign out_valid = valid_q;
  assign overrun   = ovr_q;

endmodule
